// File: rtl/down_counter_timer.sv
// Programmable down-counter/timer: counts a reload value down to zero on en ticks,
// pulsing tc once per expiry, in one-shot or periodic auto-reload mode.
module down_counter_timer #(
    parameter int unsigned WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             start,
    input  logic             stop,
    input  logic             en,
    input  logic             mode,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] rld;
    logic [WIDTH-1:0] eff_c;

    // Reload value as seen this cycle: a concurrent load overrides the stored rld
    assign eff_c = load ? din : rld;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            q     <= '0;
            rld   <= '0;
            tc    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            tc <= 1'b0;
            case (state)
                IDLE: begin
                    if (load) begin
                        rld <= din;
                        q   <= din;
                    end
                    if (start && (eff_c != '0)) begin
                        q     <= eff_c;
                        state <= RUN;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                    end
                end
                RUN: begin
                    if (load) begin
                        rld <= din;
                    end
                    if (stop) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                    end else if (en) begin
                        if (q == WIDTH'(1)) begin
                            tc <= 1'b1;
                            // A zero reload would leave q==0 in RUN, so it ends the run instead
                            if (mode && (eff_c != '0)) begin
                                q <= eff_c;
                            end else begin
                                q     <= '0;
                                state <= DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                        end else if (q > WIDTH'(1)) begin
                            q <= q - WIDTH'(1);
                        end
                    end
                end
                DONE: begin
                    if (load) begin
                        rld   <= din;
                        q     <= din;
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                    end
                    if (start && (eff_c != '0)) begin
                        q     <= eff_c;
                        state <= RUN;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    q     <= '0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_down_counter_timer.sv
// Scoreboard bench for down_counter_timer: a behavioural model predicts each cycle's
// outputs into a queue and a monitor process compares them after every rising edge.
module tb_down_counter_timer;

    localparam int unsigned WIDTH = 3;
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_DONE = 2;

    typedef struct {
        logic [WIDTH-1:0] q;
        logic             tc;
        logic             busy;
        logic             done;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             load, start, stop, en, mode;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] q;
    logic             tc, busy, done;

    exp_t sbq[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   active = 1'b0;

    int m_st, m_q, m_rld, m_tc;

    down_counter_timer #(.WIDTH(WIDTH)) dut (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .din  (din),
        .start(start),
        .stop (stop),
        .en   (en),
        .mode (mode),
        .q    (q),
        .tc   (tc),
        .busy (busy),
        .done (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp_v);
        end
    endtask

    // Behavioural reference: one clock edge of the timer's documented rules
    task automatic model_step(input int l, input int d, input int s, input int sp,
                              input int e, input int md);
        int nxt;
        m_tc = 0;
        if (m_st == M_IDLE || m_st == M_DONE) begin
            if (l != 0) begin
                m_rld = d;
                m_q   = d;
                m_st  = M_IDLE;
            end
            if (s != 0 && m_rld != 0) begin
                m_q  = m_rld;
                m_st = M_RUN;
            end
        end else begin
            if (l != 0) m_rld = d;
            if (sp != 0) begin
                m_st = M_IDLE;
            end else if (e != 0) begin
                nxt = m_q - 1;
                if (nxt == 0) begin
                    m_tc = 1;
                    if (md != 0 && m_rld != 0) begin
                        m_q = m_rld;
                    end else begin
                        m_q  = 0;
                        m_st = M_DONE;
                    end
                end else begin
                    m_q = nxt;
                end
            end
        end
    endtask

    task automatic cycle(input int l, input int d, input int s, input int sp,
                         input int e, input int md);
        exp_t x;
        @(negedge clk);
        rst   = 1'b1;
        load  = l[0];
        din   = WIDTH'(d);
        start = s[0];
        stop  = sp[0];
        en    = e[0];
        mode  = md[0];
        model_step(l, d, s, sp, e, md);
        x.q    = WIDTH'(m_q);
        x.tc   = m_tc[0];
        x.busy = (m_st == M_RUN);
        x.done = (m_st == M_DONE);
        sbq.push_back(x);
        active = 1'b1;
    endtask

    task automatic reset_mid();
        exp_t x;
        @(negedge clk);
        rst = 1'b0;
        {load, start, stop, en, mode} = '0;
        #1;
        chk("async_rst_q", int'(q), 0);
        chk("async_rst_tc", int'(tc), 0);
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_done", int'(done), 0);
        m_st = M_IDLE; m_q = 0; m_rld = 0; m_tc = 0;
        x.q = '0; x.tc = 1'b0; x.busy = 1'b0; x.done = 1'b0;
        sbq.push_back(x);
    endtask

    always begin
        @(posedge clk);
        #1;
        cyc++;
        if (sbq.size() > 0) begin
            mon_e = sbq.pop_front();
            chk("q", int'(q), int'(mon_e.q));
            chk("tc", int'(tc), int'(mon_e.tc));
            chk("busy", int'(busy), int'(mon_e.busy));
            chk("done", int'(done), int'(mon_e.done));
        end else if (active) begin
            chk("scoreboard_underflow", 0, 1);
        end
    end

    initial begin
        int d, l, md, k;
        rst = 1'b0;
        {load, start, stop, en, mode} = '0;
        din = '0;
        m_st = M_IDLE; m_q = 0; m_rld = 0; m_tc = 0;
        @(posedge clk);
        #2;
        chk("reset_q", int'(q), 0);
        chk("reset_tc", int'(tc), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);

        // One-shot from 5
        cycle(1, 5, 0, 0, 0, 0);
        cycle(0, 0, 1, 0, 1, 0);
        for (int i = 0; i < 8; i++) cycle(0, 0, 0, 0, 1, 0);

        // Periodic from 3, then abort
        cycle(1, 3, 0, 0, 0, 1);
        cycle(0, 0, 1, 0, 0, 1);
        for (int i = 0; i < 10; i++) cycle(0, 0, 0, 0, 1, 1);
        cycle(0, 0, 0, 1, 1, 1);

        // Max value with en toggling
        cycle(1, 7, 0, 0, 0, 0);
        cycle(0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 18; i++) cycle(0, 0, 0, 0, (i % 2 == 0) ? 1 : 0, 0);

        // Stop colliding with expiry, then a zero start
        cycle(1, 4, 0, 0, 0, 0);
        cycle(0, 0, 1, 0, 0, 0);
        k = 0;
        while (m_q != 1 && k < 10) begin
            cycle(0, 0, 0, 0, 1, 0);
            k++;
        end
        cycle(0, 0, 0, 1, 1, 0);
        cycle(1, 0, 0, 0, 0, 0);
        cycle(0, 0, 1, 0, 1, 0);
        cycle(0, 0, 0, 0, 1, 0);

        // Periodic reload changed mid-period
        cycle(1, 2, 0, 0, 0, 1);
        cycle(0, 0, 1, 0, 0, 1);
        cycle(1, 5, 0, 0, 1, 1);
        for (int i = 0; i < 12; i++) cycle(0, 0, 0, 0, 1, 1);
        cycle(0, 0, 0, 1, 0, 1);

        // Async reset mid one-shot run, then start from rld=0
        cycle(1, 6, 0, 0, 0, 0);
        cycle(0, 0, 1, 0, 0, 0);
        k = 0;
        while (m_q != 3 && k < 10) begin
            cycle(0, 0, 0, 0, 1, 0);
            k++;
        end
        reset_mid();
        cycle(0, 0, 1, 0, 1, 0);
        cycle(0, 0, 0, 0, 1, 0);

        // Periodic N=1: tc continuously high
        cycle(1, 1, 1, 0, 1, 1);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 1, 1);
        cycle(0, 0, 0, 1, 1, 1);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            l  = ($urandom_range(0, 7) == 0) ? 1 : 0;
            d  = (m_st == M_RUN) ? int'($urandom_range(1, 7)) : int'($urandom_range(0, 7));
            md = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 1)) : 1;
            if (i % 400 < 200) md = 0;
            cycle(l, d,
                  ($urandom_range(0, 5) == 0) ? 1 : 0,
                  ($urandom_range(0, 24) == 0) ? 1 : 0,
                  ($urandom_range(0, 3) != 0) ? 1 : 0,
                  md);
            if ($urandom_range(0, 499) == 0) reset_mid();
        end

        @(posedge clk);
        #3;
        active = 1'b0;
        chk("scoreboard_drain", sbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/down_counter_timer.md
# down_counter_timer

Programmable N-bit down-counter/timer: the count-down counterpart to the team's up-counter blocks. It holds a reload value and counts it down to zero on qualified clock-enable ticks. It flags expiry with a one-cycle terminal-count pulse, in one-shot or periodic (auto-reload) mode. It sits beside the free-running up counters as the interval/timeout generator for control logic.

## Interface
- WIDTH, 3, counter and reload register width (>= 2)
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low
- load  in  1  write din into reload register rld (see Operation for q effect)
- din  in  WIDTH  preload value
- start  in  1  begin counting from rld (IDLE/DONE only)
- stop  in  1  abort a run (RUN only)
- en  in  1  count tick qualifier; one decrement per clk edge with en=1 in RUN
- mode  in  1  0 = one-shot, 1 = periodic auto-reload
- q  out  WIDTH  current count
- tc  out  1  terminal-count pulse, registered, high exactly one cycle per expiry
- busy  out  1  high while state = RUN
- done  out  1  high while state = DONE

## Operation
- Reset (rst=0, async): state IDLE, q=0, rld=0, tc=0, busy=0, done=0. Held while rst=0.
- States: IDLE, RUN, DONE. busy and done decode from state.
- IDLE:
  - load: rld<=din, q<=din.
  - start: q<=rld, go RUN.
  - load and start together: rld<=din, q<=din, go RUN using din.
  - Start with an effective reload of 0 is ignored: stays IDLE, no tc.
  - en is ignored.
- RUN, en=1, q>1: q<=q-1.
- RUN, en=1, q==1 (expiry): tc<=1 for the next cycle.
  - mode=0: q<=0, go DONE.
  - mode=1: q<=rld, stay RUN.
- RUN, en=0: q holds, no tc.
- RUN, stop=1: go IDLE, q holds current value, no tc.
  - stop has priority over decrement and expiry in the same cycle. No tc is generated.
- RUN, load: rld<=din only, q unaffected. New value is used at the next reload or start.
  - Expiry and load in the same cycle (periodic): reload uses the new din.
- DONE: q=0, held.
  - start: q<=rld, go RUN; ignored if rld==0.
  - load: rld<=din, q<=din, go IDLE.
  - load and start together: as in IDLE.
  - stop and en are ignored.
- mode is sampled only at the expiry edge; changing it mid-run takes effect at the next expiry.
- Arithmetic is unsigned modulo 2^WIDTH, but q never decrements below 0 (no wrap to all-ones). q==0 cannot occur in RUN.
- start in RUN is ignored. stop outside RUN is ignored.

## Timing
- start at edge k: q=rld and busy=1 visible after edge k. The first decrement is at the first later edge with en=1.
- With en held high and rld=N: expiry edge is k+N, and tc is high during the cycle after edge k+N.
  - One-shot: busy falls and done rises at edge k+N.
  - Periodic: tc period = N clk cycles, with no gap cycle at reload.
- tc is a registered output with no combinational path from inputs. It is cleared at the edge after it is asserted unless another expiry occurs.
  - Periodic mode with N=1 and en held high gives tc continuously high.
- Asynchronous reset mid-run: all outputs return to reset values immediately. A pending tc is dropped.
- All input changes take effect at the next rising clk edge.

## Test plan
- Reset, load din=5, start, mode=0, en=1 -> q = 5,4,3,2,1,0 on successive edges; tc high for one cycle after q reaches 0; done=1, busy=0; q stays 0.
- Load 3, start, mode=1, en=1 for 10 cycles -> q cycles 3,2,1,3,2,1…; tc high once every 3 cycles; busy stays 1.
- Load 7 (WIDTH=3 max), start, en toggling 1,0,1,0 -> q decrements only on en=1 edges; tc appears after 7 en ticks (14 cycles); no wrap past 0.
- Load 4, start, en=1; at q=1 assert stop in the same cycle -> state IDLE, q=1, tc never asserted. Then load 0 and start -> ignored, stays IDLE.
- Periodic run with rld=2; load din=5 mid-run -> current period finishes at 2, the next period counts 5..1; tc spacing goes 2 then 5.
- One-shot with rld=6, pull rst low at q=3 -> q=0, tc=0, busy=0, done=0 immediately; after release, start counts from rld=0 -> ignored.
